// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - request front-end for a single-port memory with init fill and 2-entry read response buffer
module mem_req_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] FILL_DATA = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_start,
  output logic                  fill_busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   fill_cnt;
  logic [1:0]              count;
  logic                    inflight;
  logic [DATA_WIDTH-1:0]   buf0;
  logic [DATA_WIDTH-1:0]   buf1;

  logic                    pop;
  logic                    push;
  logic                    xfer;
  logic                    rd_ok;
  logic [2:0]              occ;

  // Handshake and memory-port drive; everything is forced to its idle value while rst is low
  always_comb begin
    fill_busy   = 1'b1;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_data   = '0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    xfer        = 1'b0;
    occ         = {1'b0, count} + {2'b00, inflight};
    pop         = 1'b0;
    rd_ok       = 1'b0;
    push        = inflight;
    if (rst) begin
      resp_valid = (count != 2'd0);
      resp_data  = buf0;
      pop        = resp_valid & resp_ready;
      // a read may go out only if its response is guaranteed a buffer slot
      rd_ok      = occ < ({2'b00, pop} + 3'd2);
      if (state == INIT) begin
        mem_wr_en   = 1'b1;
        mem_addr    = fill_cnt;
        mem_wr_data = FILL_DATA;
      end else begin
        fill_busy = 1'b0;
        req_ready = req_write | rd_ok;
        xfer      = req_valid & req_ready;
        mem_wr_en = xfer & req_write;
        mem_rd_en = xfer & ~req_write;
        if (xfer) begin
          mem_addr    = req_addr;
          mem_wr_data = req_wdata;
        end
      end
    end
  end

  // INIT/RUN sequencing and fill address counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= INIT;
      fill_cnt <= '0;
    end else if (state == INIT) begin
      if (fill_cnt == LAST_ADDR) begin
        state    <= RUN;
        fill_cnt <= '0;
      end else begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end else if (fill_start) begin
      state    <= INIT;
      fill_cnt <= '0;
    end
  end

  // Read-response capture into a 2-deep FIFO; buf0 is always the head
  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= 2'd0;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= mem_rd_en;
      case ({push, pop})
        2'b11: begin
          if (count == 2'd1) begin
            buf0 <= mem_rd_data;
          end else begin
            buf0 <= buf1;
            buf1 <= mem_rd_data;
          end
        end
        2'b10: begin
          if (count == 2'd0) buf0 <= mem_rd_data;
          else               buf1 <= mem_rd_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          buf0  <= buf1;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Request front-end that sits directly upstream of the single-port memory. It accepts read/write requests on a valid/ready handshake and drives the memory's write-enable, read-enable, address and write-data pins. It captures read data one cycle after issue into a 2-entry response buffer with its own valid/ready handshake. After every reset, and on command, it runs an initialisation sequence that writes a fill value to every memory location.

## Interface
- ADDR_WIDTH, 3, memory address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 8, data word width
- FILL_DATA, 8'h00 (DATA_WIDTH bits), value written to every location during INIT
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low (sampled on rising clk edge while 0)
- fill_start  in  1  one-cycle pulse; requests re-initialisation of the memory
- fill_busy  out  1  high while in INIT
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready at rising edge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data (ignored for reads)
- resp_valid  out  1  read response available
- resp_ready  in  1  consumer takes response when resp_valid & resp_ready
- resp_data  out  DATA_WIDTH  read data, in request order
- mem_wr_en  out  1  to memory wr_en
- mem_rd_en  out  1  to memory rd_en
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_wr_data  out  DATA_WIDTH  to memory wr_data
- mem_rd_data  in  DATA_WIDTH  from memory rd_data (registered in memory, 1-cycle latency)

## Operation
- States: INIT, RUN.
- Reset (rst=0 at edge) → INIT with fill_cnt=0. Response buffer is emptied, inflight=0, and any pending response is discarded.
- INIT: mem_wr_en=1, mem_rd_en=0, mem_addr=fill_cnt, mem_wr_data=FILL_DATA.
  - fill_cnt increments each cycle.
  - After the write at address 2**ADDR_WIDTH-1, go to RUN and clear fill_cnt.
  - req_ready=0 and fill_busy=1 throughout INIT.
  - fill_start is ignored in INIT.
- RUN: fill_busy=0. The memory port is driven combinationally from the request:
  - mem_wr_en = req_valid & req_ready & req_write
  - mem_rd_en = req_valid & req_ready & !req_write
  - mem_addr = req_addr
  - mem_wr_data = req_wdata
  - With no transfer, both enables are 0. mem_addr and mem_wr_data are don't-care but must be held at 0.
- req_ready in RUN:
  - Writes are always ready.
  - Reads are ready when count + inflight − pop < 2, where count is buffer occupancy, inflight = 1 if a read was issued in the previous cycle, and pop = resp_valid & resp_ready.
  - This is a combinational path from resp_ready to req_ready. It is permitted and documented.
- fill_start in RUN: any request handshake in that same cycle completes normally; INIT begins on the next cycle.
- Response path:
  - If inflight=1, mem_rd_data is pushed into the buffer at the edge, even while in INIT.
  - Buffer is a FIFO, 2 entries deep.
  - resp_valid = (count>0); resp_data = head entry.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow cannot occur by construction. The bench asserts count ≤ 2.
- Ordering: memory accesses are issued in acceptance order. A read following a write to the same address in the next cycle returns the new data.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_data=0, fill_busy=1, mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wr_data=0 during the rst=0 cycle. INIT drive starts on the first cycle after rst=1.
- INIT duration: exactly 2**ADDR_WIDTH cycles (8 at default). req_ready rises in the cycle after the last fill write.
- Read latency: read accepted at edge T → memory updates rd_data at T → buffer captures at T+1 → resp_valid high in the cycle after T+1. That is 2 cycles from acceptance to response.
- Throughput: 1 read or write per cycle sustained when resp_ready=1.
- rst=0 during INIT restarts INIT at address 0. rst=0 with reads in flight drops them, and no resp_valid follows.

## Test plan
- Reset release, ADDR_WIDTH=3 → fill_busy=1 for 8 cycles, mem_wr_en=1 with mem_addr 0..7 and mem_wr_data=00, then req_ready=1 and fill_busy=0.
- Write addr 3 = A5, next cycle read addr 3, resp_ready=1 → resp_valid one cycle later than the cycle after the read handshake, with resp_data=A5. Read addr 5 → 00.
- resp_ready=0, reads of addr 1 (11), 2 (22), 4 (44) back-to-back → first two accepted, third stalls with req_ready=0. Raise resp_ready → responses 11, 22, 44 in order, with no loss or duplication.
- Continuous reads of addr 0..7 with resp_ready=1 → req_ready never drops, and 8 responses arrive on 8 consecutive cycles.
- Read addr 6 (66) issued in the same cycle as fill_start → response 66 still delivered. After the 8-cycle INIT, reading addr 6 returns 00.
- rst=0 for one cycle when fill_cnt=4 → INIT restarts at mem_addr 0 and runs a full 8 cycles. A read pending at reset produces no response.
